// File: rtl/id_ctrl_seq.sv
// Registered ID-stage decode/control with hazard freeze/flush and a block-transfer
// sequencer that expands one LDM/STM-style instruction into one beat per listed register.
module id_ctrl_seq #(
    parameter int NREG  = 16,
    parameter int CMD_W = 4,
    parameter int IDX_W = $clog2(NREG),
    parameter int OFF_W = $clog2(NREG) + 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             freeze,
    input  logic             flush,
    input  logic [1:0]       mode,
    input  logic [3:0]       opcode,
    input  logic             S,
    input  logic [NREG-1:0]  reg_list,
    output logic             ex_valid,
    output logic [CMD_W-1:0] exe_cmd,
    output logic             mem_r_en,
    output logic             mem_w_en,
    output logic             wb_en,
    output logic             b,
    output logic             stat_update,
    output logic [IDX_W-1:0] xfer_reg,
    output logic [OFF_W-1:0] xfer_offset,
    output logic             busy
);

    typedef enum logic [0:0] {IDLE = 1'b0, XFER = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [NREG-1:0]  rem_q, rem_d;
    logic             s_q, s_d;
    logic             ex_valid_q, ex_valid_d;
    logic [CMD_W-1:0] exe_cmd_q, exe_cmd_d;
    logic             mem_r_en_q, mem_r_en_d;
    logic             mem_w_en_q, mem_w_en_d;
    logic             wb_en_q, wb_en_d;
    logic             b_q, b_d;
    logic             stat_update_q, stat_update_d;
    logic [IDX_W-1:0] xfer_reg_q, xfer_reg_d;
    logic [OFF_W-1:0] xfer_offset_q, xfer_offset_d;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [NREG-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [NREG-1:0] clear_lowest(input logic [NREG-1:0] v);
        return v & (v - NREG'(1));
    endfunction

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rem_q         <= '0;
            s_q           <= 1'b0;
            ex_valid_q    <= 1'b0;
            exe_cmd_q     <= '0;
            mem_r_en_q    <= 1'b0;
            mem_w_en_q    <= 1'b0;
            wb_en_q       <= 1'b0;
            b_q           <= 1'b0;
            stat_update_q <= 1'b0;
            xfer_reg_q    <= '0;
            xfer_offset_q <= '0;
        end else begin
            state_q       <= state_d;
            rem_q         <= rem_d;
            s_q           <= s_d;
            ex_valid_q    <= ex_valid_d;
            exe_cmd_q     <= exe_cmd_d;
            mem_r_en_q    <= mem_r_en_d;
            mem_w_en_q    <= mem_w_en_d;
            wb_en_q       <= wb_en_d;
            b_q           <= b_d;
            stat_update_q <= stat_update_d;
            xfer_reg_q    <= xfer_reg_d;
            xfer_offset_q <= xfer_offset_d;
        end
    end

    // Next-state: sequencer state, remaining register list, latched load/store direction
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        s_d     = s_q;
        if (flush) begin
            state_d = IDLE;
            rem_d   = '0;
        end else if (freeze) begin
            state_d = state_q;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && (mode == 2'd3)) begin
                        rem_d = clear_lowest(reg_list);
                        if (clear_lowest(reg_list) != '0) begin
                            state_d = XFER;
                            s_d     = S;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                XFER: begin
                    rem_d = clear_lowest(rem_q);
                    if (clear_lowest(rem_q) == '0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = XFER;
                    end
                end
                default: begin
                    state_d = IDLE;
                    rem_d   = '0;
                end
            endcase
        end
    end

    // Output decode: next registered control word and the busy indication
    always_comb begin
        ex_valid_d    = 1'b0;
        exe_cmd_d     = '0;
        mem_r_en_d    = 1'b0;
        mem_w_en_d    = 1'b0;
        wb_en_d       = 1'b0;
        b_d           = 1'b0;
        stat_update_d = 1'b0;
        xfer_reg_d    = '0;
        xfer_offset_d = '0;
        busy          = (state_q == XFER);
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (freeze) begin
            ex_valid_d    = ex_valid_q;
            exe_cmd_d     = exe_cmd_q;
            mem_r_en_d    = mem_r_en_q;
            mem_w_en_d    = mem_w_en_q;
            wb_en_d       = wb_en_q;
            b_d           = b_q;
            stat_update_d = stat_update_q;
            xfer_reg_d    = xfer_reg_q;
            xfer_offset_d = xfer_offset_q;
        end else if (state_q == XFER) begin
            ex_valid_d    = 1'b1;
            exe_cmd_d     = 4'b0010;
            mem_r_en_d    = s_q;
            mem_w_en_d    = ~s_q;
            wb_en_d       = s_q;
            xfer_reg_d    = lowest_set(rem_q);
            xfer_offset_d = xfer_offset_q + OFF_W'(4);
        end else if (in_valid) begin
            ex_valid_d = 1'b1;
            case (mode)
                2'd0: begin
                    stat_update_d = S;
                    wb_en_d       = 1'b1;
                    case (opcode)
                        4'd0:    exe_cmd_d = 4'b0110;
                        4'd1:    exe_cmd_d = 4'b1000;
                        4'd2:    exe_cmd_d = 4'b0100;
                        4'd4:    exe_cmd_d = 4'b0010;
                        4'd5:    exe_cmd_d = 4'b0011;
                        4'd6:    exe_cmd_d = 4'b0101;
                        4'd8: begin
                            exe_cmd_d = 4'b0110;
                            wb_en_d   = 1'b0;
                        end
                        4'd10: begin
                            exe_cmd_d = 4'b0100;
                            wb_en_d   = 1'b0;
                        end
                        4'd12:   exe_cmd_d = 4'b0111;
                        4'd13:   exe_cmd_d = 4'b0001;
                        4'd15:   exe_cmd_d = 4'b1001;
                        default: begin
                            exe_cmd_d     = '0;
                            wb_en_d       = 1'b0;
                            stat_update_d = 1'b0;
                        end
                    endcase
                end
                2'd1: begin
                    if (opcode == 4'd4) begin
                        exe_cmd_d  = 4'b0010;
                        mem_r_en_d = S;
                        wb_en_d    = S;
                        mem_w_en_d = ~S;
                    end else begin
                        exe_cmd_d = '0;
                    end
                end
                2'd2: b_d = 1'b1;
                2'd3: begin
                    // An empty list still occupies one EX slot as a NOP
                    if (reg_list != '0) begin
                        exe_cmd_d  = 4'b0010;
                        mem_r_en_d = S;
                        mem_w_en_d = ~S;
                        wb_en_d    = S;
                        xfer_reg_d = lowest_set(reg_list);
                    end else begin
                        exe_cmd_d = '0;
                    end
                end
                default: ex_valid_d = 1'b0;
            endcase
        end else begin
            ex_valid_d = 1'b0;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign exe_cmd     = exe_cmd_q;
    assign mem_r_en    = mem_r_en_q;
    assign mem_w_en    = mem_w_en_q;
    assign wb_en       = wb_en_q;
    assign b           = b_q;
    assign stat_update = stat_update_q;
    assign xfer_reg    = xfer_reg_q;
    assign xfer_offset = xfer_offset_q;

endmodule

// File: tb/tb_id_ctrl_seq.sv
// Directed-vector bench for id_ctrl_seq: the driver queues the hand-computed control word
// expected after each edge, and an independent monitor pops and compares it.
module tb_id_ctrl_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        freeze;
    logic        flush;
    logic [1:0]  mode;
    logic [3:0]  opcode;
    logic        S;
    logic [15:0] reg_list;
    logic        ex_valid;
    logic [3:0]  exe_cmd;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        wb_en;
    logic        b;
    logic        stat_update;
    logic [3:0]  xfer_reg;
    logic [5:0]  xfer_offset;
    logic        busy;

    typedef struct {
        string       name;
        logic [20:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    id_ctrl_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .freeze(freeze), .flush(flush),
        .mode(mode), .opcode(opcode), .S(S), .reg_list(reg_list),
        .ex_valid(ex_valid), .exe_cmd(exe_cmd), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .wb_en(wb_en), .b(b), .stat_update(stat_update), .xfer_reg(xfer_reg),
        .xfer_offset(xfer_offset), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed expected word: {ex_valid, cmd, r, w, wb, b, stat, reg, off, busy}
    function automatic logic [20:0] mk(input logic ev, input logic [3:0] cmd, input logic r,
                                       input logic w, input logic wb, input logic br,
                                       input logic st, input logic [3:0] rg,
                                       input logic [5:0] off, input logic bsy);
        return {ev, cmd, r, w, wb, br, st, rg, off, bsy};
    endfunction

    localparam logic [20:0] ZERO = 21'd0;

    task automatic drive(input logic r_i, input logic iv, input logic frz, input logic fl,
                         input logic [1:0] md, input logic [3:0] op, input logic s_i,
                         input logic [15:0] rl, input string nm, input logic [20:0] e);
        exp_t x;
        rst      = r_i;
        in_valid = iv;
        freeze   = frz;
        flush    = fl;
        mode     = md;
        opcode   = op;
        S        = s_i;
        reg_list = rl;
        x.name   = nm;
        x.v      = e;
        exp_q.push_back(x);
        @(negedge clk);
    endtask

    // Monitor: one comparison per queued expectation, sampled just after the rising edge
    initial begin
        exp_t        e;
        logic [20:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                act = {ex_valid, exe_cmd, mem_r_en, mem_w_en, wb_en, b, stat_update,
                       xfer_reg, xfer_offset, busy};
                vectors++;
                if (act !== e.v) begin
                    miscompares++;
                    $display("FAIL %s: got %h want %h", e.name, act, e.v);
                end
            end
        end
    end

    initial begin
        // Reset with arbitrary (X-free) inputs
        drive(1'b1, 1'b1, 1'($urandom), 1'b0, 2'($urandom), 4'($urandom), 1'($urandom),
              16'($urandom), "reset0", ZERO);
        drive(1'b1, 1'b1, 1'($urandom), 1'($urandom), 2'd3, 4'($urandom), 1'($urandom),
              16'hFFFF, "reset1", ZERO);

        // Data processing, branch, bubble
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd4,  1'b1, 16'h0, "add_s",
              mk(1'b1, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 6'd0, 1'b0));
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd10, 1'b1, 16'h0, "cmp_s",
              mk(1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 6'd0, 1'b0));
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd13, 1'b0, 16'h0, "mov",
              mk(1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 6'd0, 1'b0));
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd7,  1'b1, 16'h0, "dp_undef",
              mk(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 6'd0, 1'b0));
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 4'd9,  1'b1, 16'hFFFF, "branch",
              mk(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 6'd0, 1'b0));
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd4,  1'b1, 16'h0, "bubble", ZERO);

        // Single memory transfer
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 4'd4, 1'b1, 16'h0, "ldr",
              mk(1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 6'd0, 1'b0));
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 4'd4, 1'b0, 16'h0, "str",
              mk(1'b1, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 6'd0, 1'b0));

        // LDM list 0x000B; the XFER beats ignore the (branch) inputs
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 4'd0, 1'b1, 16'h000B, "ldm_b0",
              mk(1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 6'd0, 1'b1));
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 4'd0, 1'b0, 16'h0000, "ldm_b1",
              mk(1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 6'd4, 1'b1));
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 16'h0000, "ldm_b2",
              mk(1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 6'd8, 1'b0));

        // STM list 0x8001 with a 3-cycle freeze mid-transfer
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 4'd0, 1'b0, 16'h8001, "stm_b0",
              mk(1'b1, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 6'd0, 1'b1));
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 4'd4, 1'b1, 16'h00FF, "stm_frz",
                  mk(1'b1, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 6'd0, 1'b1));
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 16'h0, "stm_b1",
              mk(1'b1, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd15, 6'd4, 1'b0));

        // LDM list 0x00F0 flushed on its second beat, then a normal instruction
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 4'd0, 1'b1, 16'h00F0, "fl_b0",
              mk(1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4, 6'd0, 1'b1));
        drive(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 4'd4, 1'b1, 16'h0, "fl_kill", ZERO);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd4, 1'b0, 16'h0, "fl_next",
              mk(1'b1, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 6'd0, 1'b0));

        // Freeze in IDLE holds the previous word; flush wins over freeze
        drive(1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 4'd0, 1'b0, 16'h0, "frz_idle",
              mk(1'b1, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 6'd0, 1'b0));
        drive(1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 4'd0, 1'b0, 16'h0, "fl_over_frz", ZERO);

        // Empty list gives one NOP; single-bit list gives one beat without busy
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 4'd0, 1'b1, 16'h0000, "ldm_empty",
              mk(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 6'd0, 1'b0));
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 4'd0, 1'b0, 16'h0400, "stm_single",
              mk(1'b1, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd10, 6'd0, 1'b0));

        // Reset mid-transfer discards the remaining beats
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 4'd0, 1'b0, 16'h0003, "rx_b0",
              mk(1'b1, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 6'd0, 1'b1));
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 16'h0, "rx_rst", ZERO);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 16'h0, "rx_after", ZERO);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
